// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60Hz VGA timing from the 50 MHz system clock.
//
// A clock-enable divider produces one pixel advance every CLK_DIV system
// clocks; there is no second clock domain. Every output is a flop, so the
// pins never see a combinational path from the counters.
//
// Optional feature macro: VGA_LOOKAHEAD_EN adds next_x / next_y /
// next_visible, the position (and its visible flag) that the next pix_en
// will present.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   ena          in   run enable; low freezes all state, strobes drop to 0
//   pix_en       out  one-clk pulse on each pixel advance
//   hsync        out  horizontal sync, active level HSYNC_POL
//   vsync        out  vertical sync, active level VSYNC_POL
//   visible      out  position inside the active area
//   x_coord      out  horizontal position 0..H_TOTAL-1
//   y_coord      out  vertical position 0..V_TOTAL-1
//   line_start   out  one-clk pulse when x_coord becomes 0
//   frame_start  out  one-clk pulse when the position becomes (0,0)
//   frame_count  out  frames started since reset, wraps at 8 bits
//   next_x/next_y/next_visible (VGA_LOOKAHEAD_EN only) look-ahead position
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic [9:0] x_coord,
    output logic [9:0] y_coord,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
`ifdef VGA_LOOKAHEAD_EN
    ,
    output logic [9:0] next_x,
    output logic [9:0] next_y,
    output logic       next_visible
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so an end value of exactly 1024 still compares correctly.
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Counters are 10 bits wide; larger timings cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
    } pos_t;

    // Raster-order successor of (h,v), wrapping at the end of line and frame.
    function automatic pos_t step_pos(input pos_t p);
        pos_t n;
        n = p;
        if (p.h == H_LAST) begin
            n.h = '0;
            n.v = (p.v == V_LAST) ? '0 : p.v + 10'd1;
        end else begin
            n.h = p.h + 10'd1;
        end
        return n;
    endfunction

    function automatic logic is_visible(input pos_t p);
        return ({1'b0, p.h} < H_ACT) && ({1'b0, p.v} < V_ACT);
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    pos_t             pos_q, pos_d;
    logic             pix_en_q, pix_en_d;
    logic             visible_q, visible_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic [7:0]       frame_count_q, frame_count_d;
    logic             adv;

    always_comb begin
        adv           = ena && (div_q == DIV_LAST);
        div_d         = div_q;
        pos_d         = pos_q;
        pix_en_d      = adv;
        visible_d     = visible_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;

        if (ena) begin
            div_d = adv ? '0 : div_q + 1'b1;
        end

        // Outputs are decoded from the new position so they line up with it.
        if (adv) begin
            pos_d     = step_pos(pos_q);
            visible_d = is_visible(pos_d);
            hsync_d   = ({1'b0, pos_d.h} >= HS_BEG && {1'b0, pos_d.h} < HS_END)
                        ? HSYNC_POL : ~HSYNC_POL;
            // v only moves when h wraps, so vsync changes at the h=0 boundary.
            vsync_d   = ({1'b0, pos_d.v} >= VS_BEG && {1'b0, pos_d.v} < VS_END)
                        ? VSYNC_POL : ~VSYNC_POL;
            line_start_d  = (pos_d.h == '0);
            frame_start_d = (pos_d.h == '0) && (pos_d.v == '0);
            if (frame_start_d) begin
                frame_count_d = frame_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            pos_q         <= '{h: H_LAST, v: V_LAST};
            pix_en_q      <= 1'b0;
            visible_q     <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            div_q         <= div_d;
            pos_q         <= pos_d;
            pix_en_q      <= pix_en_d;
            visible_q     <= visible_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign pix_en      = pix_en_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign visible     = visible_q;
    assign x_coord     = pos_q.h;
    assign y_coord     = pos_q.v;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

`ifdef VGA_LOOKAHEAD_EN
    // Always one step ahead of pos_q; the reset value is the successor of
    // the reset position, i.e. (0,0).
    pos_t nxt_q, nxt_d;
    logic nxt_vis_q, nxt_vis_d;

    always_comb begin
        nxt_d     = nxt_q;
        nxt_vis_d = nxt_vis_q;
        if (adv) begin
            nxt_d     = step_pos(pos_d);
            nxt_vis_d = is_visible(nxt_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt_q     <= '{h: 10'd0, v: 10'd0};
            nxt_vis_q <= 1'b1;
        end else begin
            nxt_q     <= nxt_d;
            nxt_vis_q <= nxt_vis_d;
        end
    end

    assign next_x       = nxt_q.h;
    assign next_y       = nxt_q.v;
    assign next_visible = nxt_vis_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster (25x13) so whole frames
// fit in a short run. The reference model counts enabled clocks and pixel
// advances since reset and derives position, flags and strobes from the
// advance count with plain arithmetic.
module tb_vga_timing_gen;
  localparam int CLK_DIV =
`ifdef VGA_LOOKAHEAD_EN
    1;
`else
    2;
`endif
  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;   // 25
  localparam int VT = VA + VFP + VS + VBP;   // 13
  localparam int FT = HT * VT;               // 325 pixels per frame

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       pix_en, hsync, vsync, visible, line_start, frame_start;
  logic [9:0] x_coord, y_coord;
  logic [7:0] frame_count;
`ifdef VGA_LOOKAHEAD_EN
  logic [9:0] next_x, next_y;
  logic       next_visible;
`endif

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .visible(visible),
    .x_coord(x_coord), .y_coord(y_coord),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count)
`ifdef VGA_LOOKAHEAD_EN
    , .next_x(next_x), .next_y(next_y), .next_visible(next_visible)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int e_m = 0;   // enabled clock edges since reset
  int n_m = 0;   // pixel advances since reset
  bit pe_m = 0;  // pix_en expected after the last edge

  function automatic int pos_x(input int n);
    return (n == 0) ? HT - 1 : ((n - 1) % FT) % HT;
  endfunction
  function automatic int pos_y(input int n);
    return (n == 0) ? VT - 1 : ((n - 1) % FT) / HT;
  endfunction
  function automatic int vis_of(input int x, input int y);
    return (x < HA && y < VA) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_m  <= 0;
      n_m  <= 0;
      pe_m <= 1'b0;
    end else if (ena) begin
      e_m  <= e_m + 1;
      pe_m <= ((e_m + 1) % CLK_DIV == 0);
      if ((e_m + 1) % CLK_DIV == 0) n_m <= n_m + 1;
    end else begin
      pe_m <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int x, y, at0;
    x   = pos_x(n_m);
    y   = pos_y(n_m);
    at0 = (n_m > 0 && x == 0) ? 1 : 0;
    check("pix_en", 32'(pix_en), 32'(pe_m));
    check("x_coord", 32'(x_coord), x);
    check("y_coord", 32'(y_coord), y);
    check("visible", 32'(visible), (n_m == 0) ? 0 : vis_of(x, y));
    check("hsync", 32'(hsync), (x >= HA + HFP && x < HA + HFP + HS) ? 0 : 1);
    check("vsync", 32'(vsync), (y >= VA + VFP && y < VA + VFP + VS) ? 0 : 1);
    check("line_start", 32'(line_start), (pe_m && at0 == 1) ? 1 : 0);
    check("frame_start", 32'(frame_start), (pe_m && at0 == 1 && y == 0) ? 1 : 0);
    check("frame_count", 32'(frame_count), ((n_m + FT - 1) / FT) % 256);
`ifdef VGA_LOOKAHEAD_EN
    check("next_x", 32'(next_x), pos_x(n_m + 1));
    check("next_y", 32'(next_y), pos_y(n_m + 1));
    check("next_visible", 32'(next_visible), vis_of(pos_x(n_m + 1), pos_y(n_m + 1)));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, 32'(x_coord), 24);
    check({tag, "_y"}, 32'(y_coord), 12);
    check({tag, "_pix_en"}, 32'(pix_en), 0);
    check({tag, "_visible"}, 32'(visible), 0);
    check({tag, "_hsync"}, 32'(hsync), 1);
    check({tag, "_vsync"}, 32'(vsync), 1);
    check({tag, "_line_start"}, 32'(line_start), 0);
    check({tag, "_frame_start"}, 32'(frame_start), 0);
    check({tag, "_frame_count"}, 32'(frame_count), 0);
  endtask

  // Called just after a posedge with rst_n low; releases reset and checks
  // the first advance lands on (0,0) exactly CLK_DIV clocks later.
  task automatic release_and_first(input string tag);
    rst_n = 1'b1;
    for (int k = 1; k <= CLK_DIV; k++) begin
      @(posedge clk);
      #1;
      if (k < CLK_DIV) check({tag, "_early_pix_en"}, 32'(pix_en), 0);
    end
    check({tag, "_first_pix_en"}, 32'(pix_en), 1);
    check({tag, "_first_x"}, 32'(x_coord), 0);
    check({tag, "_first_y"}, 32'(y_coord), 0);
    check({tag, "_first_visible"}, 32'(visible), 1);
    check({tag, "_first_line_start"}, 32'(line_start), 1);
    check({tag, "_first_frame_start"}, 32'(frame_start), 1);
    check({tag, "_first_frame_count"}, 32'(frame_count), 1);
`ifdef VGA_LOOKAHEAD_EN
    check({tag, "_first_next_x"}, 32'(next_x), 1);
    check({tag, "_first_next_y"}, 32'(next_y), 0);
`endif
  endtask

  // Returns at the negedge of the cycle where the position became (x,y).
  task automatic wait_pos(input int x, input int y);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FT * CLK_DIV + 20 && !ok; i++) begin
      @(negedge clk);
      if (pix_en && x_coord == 10'(x) && y_coord == 10'(y)) ok = 1'b1;
    end
    check("reach_position", 32'(ok), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int adv_cnt, hs_line0, vs_low, vis_cnt, ls_cnt;
    bit done, seen;
    rst_n = 1'b1;
    ena   = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    release_and_first("start");

    // One full frame from (0,0) up to the next (0,0).
    adv_cnt = 0; hs_line0 = 0; vs_low = 0; vis_cnt = 0; ls_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 2 * FT * CLK_DIV + 20 && !done; i++) begin
      @(negedge clk);
      if (pix_en) begin
        if (frame_start && adv_cnt > 0) begin
          done = 1'b1;
        end else begin
          adv_cnt++;
          if (y_coord == 10'd0 && !hsync) hs_line0++;
          if (!vsync) vs_low++;
          if (visible) vis_cnt++;
          if (line_start) ls_cnt++;
        end
      end
    end
    check("frame_wrap_seen", 32'(done), 1);
    check("frame_pixels", adv_cnt, 325);
    check("hsync_low_pixels_line0", hs_line0, 4);
    check("vsync_low_pixels", vs_low, 50);
    check("visible_pixels", vis_cnt, 128);
    check("line_starts_per_frame", ls_cnt, 13);
    check("wrap_frame_count", 32'(frame_count), 2);
    check("wrap_x", 32'(x_coord), 0);
    check("wrap_y", 32'(y_coord), 0);

    // Freeze for 7 clocks at (10,2), then resume at (11,2).
    wait_pos(10, 2);
    ena = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      check("hold_x", 32'(x_coord), 10);
      check("hold_y", 32'(y_coord), 2);
      check("hold_pix_en", 32'(pix_en), 0);
      check("hold_line_start", 32'(line_start), 0);
      check("hold_frame_start", 32'(frame_start), 0);
      check("hold_frame_count", 32'(frame_count), 2);
    end
    ena = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < CLK_DIV + 2 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (pix_en) seen = 1'b1;
    end
    check("resume_seen", 32'(seen), 1);
    check("resume_x", 32'(x_coord), 11);
    check("resume_y", 32'(y_coord), 2);

    // Asynchronous reset mid-frame, then the start-up sequence again.
    wait_pos(15, 5);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    repeat (2) @(posedge clk);
    #1;
    release_and_first("restart");

    repeat (3 * HT * CLK_DIV) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
